// File: rtl/tft_power_sequencer.sv
// rtl/tft_power_sequencer.sv - TFT panel power-up/power-down sequencer (optional frame watchdog: TFT_PWR_WATCHDOG_EN)
module tft_power_sequencer #(
    parameter int unsigned T_VDD         = 2000,
    parameter int unsigned T_CLK         = 1000,
    parameter int unsigned BL_FRAMES     = 10,
    parameter int unsigned FRAME_TIMEOUT = 1000000,
    parameter int unsigned CNT_W         = 32
) (
    input  logic       cclk,
    input  logic       rst,
    input  logic       power_req,
    input  logic       new_frame,
    output logic       tft_vdd,
    output logic       tft_clk_ena,
    output logic       tft_display,
    output logic       tft_backlight_ena,
    output logic       ready,
    output logic       busy,
    output logic [2:0] state,
    output logic       fault
);

    typedef enum logic [2:0] {
        S_OFF        = 3'd0,
        S_VDD_UP     = 3'd1,
        S_CLK_UP     = 3'd2,
        S_WAIT_FRAME = 3'd3,
        S_BL_WAIT    = 3'd4,
        S_ON         = 3'd5,
        S_PWR_DN     = 3'd6,
        S_VDD_DN     = 3'd7
    } state_t;

`ifdef TFT_PWR_WATCHDOG_EN
    localparam bit L_WD_EN = 1'b1;
`else
    localparam bit L_WD_EN = 1'b0;
`endif

    // Last counter value of each timed state: a state lasting N cycles sees counts 0..N-1
    localparam logic [CNT_W-1:0] L_VDD_LAST = CNT_W'(T_VDD - 1);
    localparam logic [CNT_W-1:0] L_CLK_LAST = CNT_W'(T_CLK - 1);
    localparam logic [CNT_W-1:0] L_TO_LAST  = CNT_W'(FRAME_TIMEOUT - 1);
    localparam int unsigned      L_FR_W     = (BL_FRAMES > 1) ? $clog2(BL_FRAMES) : 1;
    localparam logic [L_FR_W-1:0] L_FR_LAST = L_FR_W'(BL_FRAMES - 1);

    state_t             r_state;
    logic [5:0]         r_out;     // {vdd, clk_ena, display, backlight, ready, busy}
    logic [CNT_W-1:0]   r_cnt;     // delay counter; doubles as frame watchdog in frame-wait states
    logic [L_FR_W-1:0]  r_frames;  // counted new_frame pulses while in BL_WAIT
    logic               r_fault;

    // Output pattern for a given state, registered alongside the state itself
    function automatic logic [5:0] f_outs(input state_t s);
        case (s)
            S_OFF:        f_outs = 6'b0000_00;
            S_VDD_UP:     f_outs = 6'b1000_01;
            S_CLK_UP:     f_outs = 6'b1100_01;
            S_WAIT_FRAME: f_outs = 6'b1100_01;
            S_BL_WAIT:    f_outs = 6'b1110_01;
            S_ON:         f_outs = 6'b1111_10;
            S_PWR_DN:     f_outs = 6'b1100_01;
            S_VDD_DN:     f_outs = 6'b1000_01;
            default:      f_outs = 6'b0000_00;
        endcase
    endfunction

    // Sequencer FSM: power-down requests take priority over delays and frame events
    always_ff @(posedge cclk) begin
        if (rst) begin
            r_state  <= S_OFF;
            r_out    <= 6'b0;
            r_cnt    <= '0;
            r_frames <= '0;
            r_fault  <= 1'b0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            case (r_state)
                S_OFF: begin
                    if (power_req && !r_fault) begin
                        r_state <= S_VDD_UP;
                        r_out   <= f_outs(S_VDD_UP);
                        r_cnt   <= '0;
                    end
                end
                S_VDD_UP: begin
                    if (!power_req) begin
                        r_state <= S_VDD_DN;
                        r_out   <= f_outs(S_VDD_DN);
                        r_cnt   <= '0;
                    end else if (r_cnt == L_VDD_LAST) begin
                        r_state <= S_CLK_UP;
                        r_out   <= f_outs(S_CLK_UP);
                        r_cnt   <= '0;
                    end
                end
                S_CLK_UP: begin
                    if (!power_req) begin
                        r_state <= S_PWR_DN;
                        r_out   <= f_outs(S_PWR_DN);
                        r_cnt   <= '0;
                    end else if (r_cnt == L_CLK_LAST) begin
                        r_state <= S_WAIT_FRAME;
                        r_out   <= f_outs(S_WAIT_FRAME);
                        r_cnt   <= '0;
                    end
                end
                S_WAIT_FRAME: begin
                    if (!power_req) begin
                        r_state <= S_PWR_DN;
                        r_out   <= f_outs(S_PWR_DN);
                        r_cnt   <= '0;
                    end else if (new_frame) begin
                        r_state  <= S_BL_WAIT;
                        r_out    <= f_outs(S_BL_WAIT);
                        r_cnt    <= '0;
                        r_frames <= '0;
                    end else if (L_WD_EN && r_cnt == L_TO_LAST) begin
                        r_state <= S_PWR_DN;
                        r_out   <= f_outs(S_PWR_DN);
                        r_cnt   <= '0;
                        r_fault <= 1'b1;
                    end
                end
                S_BL_WAIT: begin
                    if (!power_req) begin
                        r_state <= S_PWR_DN;
                        r_out   <= f_outs(S_PWR_DN);
                        r_cnt   <= '0;
                    end else if (new_frame) begin
                        r_cnt <= '0;
                        if (r_frames == L_FR_LAST) begin
                            r_state <= S_ON;
                            r_out   <= f_outs(S_ON);
                        end else begin
                            r_frames <= r_frames + 1'b1;
                        end
                    end else if (L_WD_EN && r_cnt == L_TO_LAST) begin
                        r_state <= S_PWR_DN;
                        r_out   <= f_outs(S_PWR_DN);
                        r_cnt   <= '0;
                        r_fault <= 1'b1;
                    end
                end
                S_ON: begin
                    if (!power_req) begin
                        r_state <= S_PWR_DN;
                        r_out   <= f_outs(S_PWR_DN);
                        r_cnt   <= '0;
                    end
                end
                S_PWR_DN: begin
                    if (r_cnt == L_CLK_LAST) begin
                        r_state <= S_VDD_DN;
                        r_out   <= f_outs(S_VDD_DN);
                        r_cnt   <= '0;
                    end
                end
                S_VDD_DN: begin
                    if (r_cnt == L_VDD_LAST) begin
                        r_state <= S_OFF;
                        r_out   <= f_outs(S_OFF);
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= S_OFF;
                    r_out   <= f_outs(S_OFF);
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign tft_vdd           = r_out[5];
    assign tft_clk_ena       = r_out[4];
    assign tft_display       = r_out[3];
    assign tft_backlight_ena = r_out[2];
    assign ready             = r_out[1];
    assign busy              = r_out[0];
    assign state             = r_state;
    assign fault             = r_fault;

endmodule
